ram_arbiter2: RTL and testbench



---
 rtl/quasisoc_pkg.sv | 16 +
 rtl/rr_pick2.sv | 21 ++
 rtl/ram_arbiter2.sv | 214 +++++++++++++++++++++
 tb/tb_ram_arbiter2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quasisoc_pkg.sv
// quasisoc_pkg
// Shared definitions for the quasiSoC memory subsystem.
// - arb_state_e: arbiter FSM encoding (IDLE / ISSUE / CAPTURE)
// - OP_RD / OP_WE: encoding of the operation held in an arbiter slot
package quasisoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin pick.
// Ports:
//   valid0, valid1 : slot valid bits
//   prio           : port that wins when both slots are valid
//   grant          : selected port index
//   grant_valid    : at least one slot is valid (grant is meaningful)
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant,
  output logic grant_valid
);

  // With only slot 0 valid, valid1 = 0 selects port 0; with only slot 1
  // valid it selects port 1; the pointer only matters on contention.
  assign grant       = (valid0 && valid1) ? prio : valid1;
  assign grant_valid = valid0 | valid1;

endmodule

// File: rtl/ram_arbiter2.sv
// ram_arbiter2
// Shares one single-port synchronous RAM (one-cycle registered read)
// between two masters using the quasiSoC slave handshake. Requests are
// latched into one slot per port, serialised onto the RAM in round-robin
// order, and read data is returned on the owning port.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   mX_a, mX_d                : master X word address / write data
//   mX_rd, mX_we              : master X request pulses (we wins if both)
//   mX_spo                    : master X registered read data
//   mX_ready                  : master X idle / previous access complete
//   ram_a, ram_d              : RAM address / write data (hold when idle)
//   ram_rd, ram_we            : RAM strobes, high only in ISSUE
//   ram_spo                   : RAM registered read data
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no access in flight, waiting for a valid slot
// ST_ISSUE   | RAM strobe asserted for the granted slot
// ST_CAPTURE | RAM read data valid; returned to the owner, next grant
module ram_arbiter2
  import quasisoc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] m0_a,
  input  logic [WIDTH-1:0] m0_d,
  input  logic             m0_rd,
  input  logic             m0_we,
  output logic [WIDTH-1:0] m0_spo,
  output logic             m0_ready,
  input  logic [DEPTH-1:0] m1_a,
  input  logic [WIDTH-1:0] m1_d,
  input  logic             m1_rd,
  input  logic             m1_we,
  output logic [WIDTH-1:0] m1_spo,
  output logic             m1_ready,
  output logic [DEPTH-1:0] ram_a,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_we,
  output logic             ram_rd,
  input  logic [WIDTH-1:0] ram_spo
);

  arb_state_e       state_q, state_d;

  logic [1:0]       slot_vld_q, slot_vld_d;
  logic [1:0]       slot_op_q, slot_op_d;
  logic [DEPTH-1:0] slot_a_q [2];
  logic [DEPTH-1:0] slot_a_d [2];
  logic [WIDTH-1:0] slot_d_q [2];
  logic [WIDTH-1:0] slot_d_d [2];
  logic [1:0]       busy_q, busy_d;

  logic             prio_q, prio_d;
  logic             cur_port_q, cur_port_d;
  logic             cur_op_q, cur_op_d;

  logic [WIDTH-1:0] spo_q [2];
  logic [WIDTH-1:0] spo_d [2];

  logic [DEPTH-1:0] ram_a_q, ram_a_d;
  logic [WIDTH-1:0] ram_d_q, ram_d_d;
  logic             ram_rd_q, ram_rd_d;
  logic             ram_we_q, ram_we_d;

  logic [1:0]       req, req_we, free, load;
  logic [DEPTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_d [2];

  logic             pick_port, pick_vld, grant_now;

  assign req       = {m1_rd | m1_we, m0_rd | m0_we};
  assign req_we    = {m1_we, m0_we};
  assign req_a[0]  = m0_a;
  assign req_a[1]  = m1_a;
  assign req_d[0]  = m0_d;
  assign req_d[1]  = m1_d;

  // A port can take a new request only when it has nothing pending and
  // does not own the in-flight access; anything else is dropped.
  assign free      = ~(slot_vld_q | busy_q);
  assign load      = req & free;

  assign m0_ready  = ~(m0_rd | m0_we | slot_vld_q[0] | busy_q[0]);
  assign m1_ready  = ~(m1_rd | m1_we | slot_vld_q[1] | busy_q[1]);

  assign m0_spo    = spo_q[0];
  assign m1_spo    = spo_q[1];
  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign ram_rd    = ram_rd_q;
  assign ram_we    = ram_we_q;

  rr_pick2 u_pick (
    .valid0      (slot_vld_q[0]),
    .valid1      (slot_vld_q[1]),
    .prio        (prio_q),
    .grant       (pick_port),
    .grant_valid (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    slot_vld_d = slot_vld_q;
    slot_op_d  = slot_op_q;
    slot_a_d   = slot_a_q;
    slot_d_d   = slot_d_q;
    busy_d     = busy_q;
    prio_d     = prio_q;
    cur_port_d = cur_port_q;
    cur_op_d   = cur_op_q;
    spo_d      = spo_q;
    ram_a_d    = ram_a_q;
    ram_d_d    = ram_d_q;
    ram_rd_d   = 1'b0;
    ram_we_d   = 1'b0;
    grant_now  = 1'b0;

    for (int p = 0; p < 2; p++) begin
      if (load[p]) begin
        slot_vld_d[p] = 1'b1;
        slot_op_d[p]  = req_we[p] ? OP_WE : OP_RD;
        slot_a_d[p]   = req_a[p];
        slot_d_d[p]   = req_d[p];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) grant_now = 1'b1;
      end
      ST_ISSUE: begin
        // The owner is busy, so its slot cannot be reloaded here.
        slot_vld_d[cur_port_q] = 1'b0;
        state_d                = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cur_op_q == OP_RD) spo_d[cur_port_q] = ram_spo;
        busy_d[cur_port_q] = 1'b0;
        if (pick_vld) grant_now = 1'b1;
        else          state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RAM controls are registered on the grant edge so that the strobe is
    // high exactly during ISSUE and the address/data hold afterwards.
    if (grant_now) begin
      state_d            = ST_ISSUE;
      cur_port_d         = pick_port;
      cur_op_d           = slot_op_q[pick_port];
      busy_d[pick_port]  = 1'b1;
      prio_d             = ~pick_port;
      ram_a_d            = slot_a_q[pick_port];
      ram_d_d            = slot_d_q[pick_port];
      ram_rd_d           = (slot_op_q[pick_port] == OP_RD);
      ram_we_d           = (slot_op_q[pick_port] == OP_WE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q  <= '0;
      slot_op_q   <= '0;
      slot_a_q[0] <= '0;
      slot_a_q[1] <= '0;
      slot_d_q[0] <= '0;
      slot_d_q[1] <= '0;
      busy_q      <= '0;
      prio_q      <= 1'b0;
      cur_port_q  <= 1'b0;
      cur_op_q    <= OP_RD;
      spo_q[0]    <= '0;
      spo_q[1]    <= '0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      ram_rd_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_op_q   <= slot_op_d;
      slot_a_q    <= slot_a_d;
      slot_d_q    <= slot_d_d;
      busy_q      <= busy_d;
      prio_q      <= prio_d;
      cur_port_q  <= cur_port_d;
      cur_op_q    <= cur_op_d;
      spo_q       <= spo_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      ram_rd_q    <= ram_rd_d;
      ram_we_q    <= ram_we_d;
    end
  end

  // Requests on a port that is not free are dropped by the load logic;
  // these flag the master-side protocol error in simulation.
  a_m0_proto : assert property (@(posedge clk) disable iff (rst) !(req[0] && !free[0]))
    else $warning("ram_arbiter2: request on port 0 while not ready, ignored");
  a_m1_proto : assert property (@(posedge clk) disable iff (rst) !(req[1] && !free[1]))
    else $warning("ram_arbiter2: request on port 1 while not ready, ignored");

endmodule

// File: tb/tb_ram_arbiter2.sv
module tb_ram_arbiter2;
  localparam int W = 32;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [D-1:0] m0_a, m1_a, ram_a;
  logic [W-1:0] m0_d, m1_d, m0_spo, m1_spo, ram_d;
  logic [W-1:0] ram_spo = '0;
  logic         m0_rd, m0_we, m1_rd, m1_we, m0_ready, m1_ready, ram_we, ram_rd;

  typedef struct {
    logic         we;
    logic [D-1:0] a;
    logic [W-1:0] d;
  } ram_acc_t;

  logic [W-1:0] exp_spo0 [$];
  logic [W-1:0] exp_spo1 [$];
  ram_acc_t     exp_ram  [$];
  logic [W-1:0] mem [0:(1<<D)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter2 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_rd(m0_rd), .m0_we(m0_we),
    .m0_spo(m0_spo), .m0_ready(m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_rd(m1_rd), .m1_we(m1_we),
    .m1_spo(m1_spo), .m1_ready(m1_ready),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_rd(ram_rd),
    .ram_spo(ram_spo)
  );

  // Single-port synchronous RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] = ram_d;
    if (ram_rd) ram_spo <= mem[ram_a];
  end

  task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // Completion monitor: a rising ready is a completed access on that port.
  initial begin
    bit p0 = 1'b1;
    bit p1 = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        p0 = 1'b1;
        p1 = 1'b1;
      end else begin
        if (!p0 && m0_ready) begin
          if (exp_spo0.size() == 0) chk1("m0_unexpected_completion", 1'b1, 1'b0);
          else chk32("m0_spo", m0_spo, exp_spo0.pop_front());
        end
        if (!p1 && m1_ready) begin
          if (exp_spo1.size() == 0) chk1("m1_unexpected_completion", 1'b1, 1'b0);
          else chk32("m1_spo", m1_spo, exp_spo1.pop_front());
        end
        p0 = m0_ready;
        p1 = m1_ready;
      end
    end
  end

  // RAM-side monitor: every strobe must match the next expected access.
  initial begin
    ram_acc_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && (ram_rd || ram_we)) begin
        if (exp_ram.size() == 0) begin
          chk1("ram_unexpected_strobe", 1'b1, 1'b0);
        end else begin
          e = exp_ram.pop_front();
          chk1("ram_we", ram_we, e.we);
          chk1("ram_rd", ram_rd, !e.we);
          chk32("ram_a", 32'(ram_a), 32'(e.a));
          if (e.we) chk32("ram_d", ram_d, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk); #2;
  endtask

  task automatic clr();
    m0_rd = 1'b0; m0_we = 1'b0; m1_rd = 1'b0; m1_we = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clr();
    exp_spo0.delete(); exp_spo1.delete(); exp_ram.delete();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int p);
    int n = 0;
    cyc(); clr();
    while (((p == 0) ? m0_ready : m1_ready) == 1'b0 && n < 50) begin
      cyc(); clr(); n++;
    end
    chk1("wait_ready", (p == 0) ? m0_ready : m1_ready, 1'b1);
  endtask

  initial begin
    int cnt0, cnt1, n, strobes;
    bit r0, r1;

    rst = 1'b1;
    clr();
    m0_a = '0; m0_d = '0; m1_a = '0; m1_d = '0;
    for (int i = 0; i < (1 << D); i++) mem[i] = '0;
    mem[5]  = 32'hDEADBEEF;
    mem[9]  = 32'h99999999;
    mem[20] = 32'h000000A5;
    for (int i = 0; i < 10; i++) begin
      mem[100+i] = 32'hA0000000 + 32'(i);
      mem[200+i] = 32'hB0000000 + 32'(i);
    end
    cyc(); cyc();
    rst = 1'b0;
    #1;

    // Reset state
    chk1("rst_m0_ready", m0_ready, 1'b1);
    chk1("rst_m1_ready", m1_ready, 1'b1);
    chk32("rst_m0_spo", m0_spo, 32'h0);
    chk32("rst_m1_spo", m1_spo, 32'h0);
    chk32("rst_ram_a", 32'(ram_a), 32'h0);
    chk32("rst_ram_d", ram_d, 32'h0);
    chk1("rst_ram_rd", ram_rd, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);

    // Read after reset: ready low cycles 0..3, high in cycle 4
    cyc();
    m0_rd = 1'b1; m0_a = 10'd5;
    exp_spo0.push_back(32'hDEADBEEF);
    exp_ram.push_back('{we:1'b0, a:10'd5, d:32'h0});
    #1 chk1("t1_ready_c0", m0_ready, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cyc(); clr(); #1;
      chk1($sformatf("t1_ready_c%0d", c), m0_ready, (c == 4));
      if (c == 2) chk1("t1_ram_rd_c2", ram_rd, 1'b1);
      if (c == 4) chk32("t1_m0_spo_c4", m0_spo, 32'hDEADBEEF);
    end

    // Simultaneous write (port 0) and read (port 1) of address 7, prio = 0
    do_reset();
    cyc();
    m0_we = 1'b1; m0_a = 10'd7; m0_d = 32'h11;
    m1_rd = 1'b1; m1_a = 10'd7;
    exp_ram.push_back('{we:1'b1, a:10'd7, d:32'h11});
    exp_ram.push_back('{we:1'b0, a:10'd7, d:32'h0});
    exp_spo0.push_back(32'h0);
    exp_spo1.push_back(32'h11);
    #1;
    chk1("t2_m0_ready_c0", m0_ready, 1'b0);
    chk1("t2_m1_ready_c0", m1_ready, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      cyc(); clr(); #1;
      chk1($sformatf("t2_m0_ready_c%0d", c), m0_ready, (c >= 4));
      chk1($sformatf("t2_m1_ready_c%0d", c), m1_ready, (c >= 6));
    end

    // Write keeps spo: read 0xA5, write 0x3C, read back 0x3C
    cyc();
    m1_rd = 1'b1; m1_a = 10'd20;
    exp_spo1.push_back(32'hA5);
    exp_ram.push_back('{we:1'b0, a:10'd20, d:32'h0});
    wait_ready(1);
    cyc();
    m1_we = 1'b1; m1_a = 10'd20; m1_d = 32'h3C;
    exp_spo1.push_back(32'hA5);
    exp_ram.push_back('{we:1'b1, a:10'd20, d:32'h3C});
    wait_ready(1);
    #1 chk32("t3_spo_after_write", m1_spo, 32'hA5);
    cyc();
    m1_rd = 1'b1; m1_a = 10'd20;
    exp_spo1.push_back(32'h3C);
    exp_ram.push_back('{we:1'b0, a:10'd20, d:32'h0});
    wait_ready(1);

    // Fairness: both ports re-request as soon as they complete
    for (int i = 0; i < 10; i++) begin
      exp_ram.push_back('{we:1'b0, a:10'(100+i), d:32'h0});
      exp_ram.push_back('{we:1'b0, a:10'(200+i), d:32'h0});
      exp_spo0.push_back(32'hA0000000 + 32'(i));
      exp_spo1.push_back(32'hB0000000 + 32'(i));
    end
    cnt0 = 0; cnt1 = 0; n = 0;
    while ((cnt0 < 10 || cnt1 < 10 || !m0_ready || !m1_ready) && n < 200) begin
      cyc();
      r0 = m0_ready; r1 = m1_ready;
      clr();
      if (r0 && cnt0 < 10) begin m0_rd = 1'b1; m0_a = 10'(100+cnt0); cnt0++; end
      if (r1 && cnt1 < 10) begin m1_rd = 1'b1; m1_a = 10'(200+cnt1); cnt1++; end
      n++;
    end
    chk1("t4_fair_done", (n < 200), 1'b1);
    chk32("t4_ram_queue_drained", 32'(exp_ram.size()), 32'h0);

    // Reset during CAPTURE of a port 1 read with port 0 pending
    cyc();
    m1_rd = 1'b1; m1_a = 10'd5;
    exp_ram.push_back('{we:1'b0, a:10'd5, d:32'h0});
    cyc(); clr();
    cyc(); clr();
    m0_rd = 1'b1; m0_a = 10'd6;
    #1 chk1("t5_issue_c2", ram_rd, 1'b1);
    cyc(); clr();
    #1;
    chk1("t5_m0_pending", m0_ready, 1'b0);
    chk1("t5_m1_busy", m1_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk32("t5_m0_spo", m0_spo, 32'h0);
    chk32("t5_m1_spo", m1_spo, 32'h0);
    chk32("t5_ram_a", 32'(ram_a), 32'h0);
    chk32("t5_ram_d", ram_d, 32'h0);
    chk1("t5_ram_rd", ram_rd, 1'b0);
    chk1("t5_ram_we", ram_we, 1'b0);
    exp_spo0.delete(); exp_spo1.delete(); exp_ram.delete();
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk1("t5_m0_ready_after", m0_ready, 1'b1);
    chk1("t5_m1_ready_after", m1_ready, 1'b1);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      if (ram_rd || ram_we) strobes++;
    end
    chk32("t5_no_strobe", 32'(strobes), 32'h0);

    // Protocol violation: second request while busy is dropped
    cyc();
    m0_rd = 1'b1; m0_a = 10'd5;
    exp_spo0.push_back(32'hDEADBEEF);
    exp_ram.push_back('{we:1'b0, a:10'd5, d:32'h0});
    cyc(); clr();
    m0_rd = 1'b1; m0_a = 10'd9;
    #1 chk1("t6_ready_c1", m0_ready, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      cyc(); clr(); #1;
      chk1($sformatf("t6_ready_c%0d", c), m0_ready, (c == 4));
    end
    chk32("t6_m0_spo", m0_spo, 32'hDEADBEEF);
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      if (ram_rd || ram_we) strobes++;
    end
    chk32("t6_no_extra_strobe", 32'(strobes), 32'h0);

    chk32("end_exp_ram_empty", 32'(exp_ram.size()), 32'h0);
    chk32("end_exp_spo0_empty", 32'(exp_spo0.size()), 32'h0);
    chk32("end_exp_spo1_empty", 32'(exp_spo1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
